// File: rtl/cache_mem_if.sv
// Line-transfer engine between a cache controller and a word-wide memory port.
// Moves one cache line per request (fill or writeback) with a per-word ack timeout.
module cache_mem_if #(
   parameter int LINE_WORDS = 4,
   parameter int TIMEOUT    = 16
) (
   input  logic                       iCLK,
   input  logic                       iRST,
   input  logic                       iREQ_VALID,
   input  logic                       iREQ_WE,
   input  logic [31:0]                iREQ_ADDR,
   input  logic [32*LINE_WORDS-1:0]   iWB_DATA,
   output logic                       oREQ_READY,
   output logic                       oDONE,
   output logic                       oERR,
   output logic [32*LINE_WORDS-1:0]   oFILL_DATA,
   output logic                       oMEM_REQ,
   output logic                       oMEM_WE,
   output logic [31:0]                oMEM_ADDR,
   output logic [31:0]                oMEM_WDATA,
   input  logic                       iMEM_ACK,
   input  logic [31:0]                iMEM_RDATA
);

   localparam int IDX_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [31:0]      OFFSET_MASK = 32'(4 * LINE_WORDS - 1);
   localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(LINE_WORDS - 1);
   localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

   state_t                    stateReg;
   logic [IDX_W-1:0]          indexReg;
   logic [CNT_W-1:0]          countReg;
   logic                      weReg;
   logic [31:0]               baseReg;
   logic [32*LINE_WORDS-1:0]  wbLineReg;

   logic [31:0]      wbWord [LINE_WORDS];
   logic [IDX_W-1:0] nextIdx;
   logic [31:0]      nextAddr;

   for (genvar gi = 0; gi < LINE_WORDS; gi++) begin : gUnpack
      assign wbWord[gi] = wbLineReg[32*gi +: 32];
   end

   assign nextIdx  = indexReg + 1'b1;
   assign nextAddr = baseReg + (32'(nextIdx) << 2);

   always_ff @(posedge iCLK or negedge iRST) begin
      if (!iRST) begin
         stateReg   <= IDLE;
         indexReg   <= '0;
         countReg   <= '0;
         weReg      <= 1'b0;
         baseReg    <= '0;
         wbLineReg  <= '0;
         oREQ_READY <= 1'b1;
         oDONE      <= 1'b0;
         oERR       <= 1'b0;
         oFILL_DATA <= '0;
         oMEM_REQ   <= 1'b0;
         oMEM_WE    <= 1'b0;
         oMEM_ADDR  <= '0;
         oMEM_WDATA <= '0;
      end else begin
         case (stateReg)
            IDLE: begin
               // Memory ack is deliberately ignored here; only a new request moves us.
               if (iREQ_VALID) begin
                  stateReg   <= XFER;
                  indexReg   <= '0;
                  countReg   <= '0;
                  weReg      <= iREQ_WE;
                  baseReg    <= iREQ_ADDR & ~OFFSET_MASK;
                  wbLineReg  <= iWB_DATA;
                  oREQ_READY <= 1'b0;
                  oMEM_REQ   <= 1'b1;
                  oMEM_WE    <= iREQ_WE;
                  oMEM_ADDR  <= iREQ_ADDR & ~OFFSET_MASK;
                  oMEM_WDATA <= iWB_DATA[31:0];
               end
            end
            XFER: begin
               if (iMEM_ACK) begin
                  countReg <= '0;
                  if (!weReg) begin
                     oFILL_DATA[32*indexReg +: 32] <= iMEM_RDATA;
                  end
                  if (indexReg == LAST_IDX) begin
                     stateReg <= DONE;
                     oMEM_REQ <= 1'b0;
                     oDONE    <= 1'b1;
                     oERR     <= 1'b0;
                  end else begin
                     indexReg   <= nextIdx;
                     oMEM_ADDR  <= nextAddr;
                     oMEM_WDATA <= wbWord[nextIdx];
                  end
               end else if (countReg == CNT_LAST) begin
                  // Give up on this word; unreached fill words keep their old contents.
                  stateReg <= DONE;
                  oMEM_REQ <= 1'b0;
                  oDONE    <= 1'b1;
                  oERR     <= 1'b1;
               end else begin
                  countReg <= countReg + 1'b1;
               end
            end
            DONE: begin
               stateReg   <= IDLE;
               oDONE      <= 1'b0;
               oERR       <= 1'b0;
               oREQ_READY <= 1'b1;
            end
            default: begin
               stateReg   <= IDLE;
               oREQ_READY <= 1'b1;
               oMEM_REQ   <= 1'b0;
            end
         endcase
      end
   end

endmodule
